first_nios2_system_button_pio: RTL and testbench
================================================

// Module: first_nios2_system_button_pio
// PURPOSE
//   Avalon-MM slave input PIO; the read-side counterpart of the LED output PIO.
//   Synchronises WIDTH asynchronous pins and exposes their level on the bus.
//   Latches selected edges into a sticky edge-capture register and raises a
//   maskable level interrupt to the Nios II. Zero-wait-state slave on the system interconnect.
// PARAMETERS
//   WIDTH        4  number of input pins (1..32)
//   EDGE_TYPE    1  0=rising, 1=falling, 2=any edge captured
//   SYNC_STAGES  2  synchroniser flops per pin (2..4)
// PORTS
//   clk        in   1      system clock; single clock domain
//   reset      in   1      asynchronous, active-high reset
//   address    in   2      word address of register
//   chipselect in   1      slave select
//   write_n    in   1      active-low write strobe
//   writedata  in   32     write data
//   in_port    in   WIDTH  asynchronous external pins
//   readdata   out  32     read data, combinational from address and registers
//   irq        out  1      level interrupt, active-high
// BEHAVIOUR
//   Register map (unused upper bits read 0, writes ignored):
//   - 0 DATA     RO  synchronised pin level (sync chain last stage)
//   - 1 reserved     reads 0
//   - 2 IRQMASK  RW  per-bit interrupt enable, bits [WIDTH-1:0]
//   - 3 EDGECAP  R/W1C  sticky captured edges; writing 1 clears a bit, 0 keeps it
//   Bus: write takes effect on the clk edge where chipselect && !write_n;
//     reads are zero-wait, readdata valid in the same cycle as address.
//   Sync chain: sync[0] <= in_port ... sync[N-1]; prev <= sync[N-1] each clk.
//   Edge detect per bit: rise = sync[N-1] & ~prev, fall = ~sync[N-1] & prev,
//     chosen by EDGE_TYPE; gated by arm flag (below).
//   Latency: pin change set up before edge E0 -> DATA changes after E0+(SYNC_STAGES-1);
//     EDGECAP bit set after E0+SYNC_STAGES; irq high in that same cycle if masked in.
//   irq = |(EDGECAP & IRQMASK), decoded from registers; no extra pipeline.
//   Arm counter: after reset release, edge detection is suppressed until
//     SYNC_STAGES+1 clocks elapse (chain and prev filled), so pins already
//     held at a level at reset deassertion never produce a false capture.
//   Simultaneous clear-write and new edge on same bit: set wins (bit stays 1).
//   Clear-write of a bit with no new edge: bit 0 next cycle; irq drops same cycle.
//   EDGECAP bits stay set regardless of IRQMASK; unmasking a set bit
//     asserts irq in the cycle after the IRQMASK write.
//   Pulse shorter than one clk may be missed; no glitch filtering required.
//   Reset (any time, incl. mid-transfer): sync chain, prev, IRQMASK, EDGECAP,
//     arm counter -> 0; irq=0; readdata follows regs (0 for all addresses).
// TESTING
//   1 Reset with in_port=4'hF held, release -> EDGECAP stays 0, irq 0, DATA
//     reads 0xF after SYNC_STAGES clocks.
//   2 EDGE_TYPE=1, IRQMASK=0x1, drive in_port bit0 1->0 -> EDGECAP=0x1 exactly
//     SYNC_STAGES clocks later, irq=1 same cycle; write 0x1 to addr 3 -> irq=0.
//   3 Falling edge on bit2 with IRQMASK=0 -> EDGECAP=0x4, irq=0; write
//     IRQMASK=0x4 -> irq=1 in the following cycle.
//   4 Write 0x2 to EDGECAP on the same clk that a new bit1 edge is captured ->
//     EDGECAP bit1 remains 1, irq stays high.
//   5 EDGE_TYPE=2, toggle bit3 0->1->0 five clocks apart, clear in between ->
//     each transition recaptured; address 1 always reads 0x0000_0000.
//   6 Assert reset while EDGECAP=0xF, IRQMASK=0xF -> both read 0, irq=0 immediately.

Source files
------------

// File: rtl/first_nios2_system_button_pio.sv
// Avalon-MM input PIO: synchronises external pins and latches selected edges into
// a sticky write-1-to-clear capture register that drives a maskable level interrupt.
module first_nios2_system_button_pio #(
  parameter int WIDTH       = 4,
  parameter int EDGE_TYPE   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int ARM_COUNT = SYNC_STAGES + 1;
  localparam int CNT_W     = $clog2(ARM_COUNT + 1);

  typedef enum logic [1:0] {
    ADDR_DATA    = 2'd0,
    ADDR_RSVD    = 2'd1,
    ADDR_IRQMASK = 2'd2,
    ADDR_EDGECAP = 2'd3
  } reg_addr_e;

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_irq_mask;
  logic [WIDTH-1:0] r_edge_cap;
  logic [CNT_W-1:0] r_arm_cnt;

  logic [WIDTH-1:0] w_level;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_edge_sel;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_clear;
  logic             w_armed;
  logic             w_wr;
  logic             w_wr_mask;
  logic             w_wr_cap;

  assign w_level = r_sync[SYNC_STAGES-1];

  // NOTE: every synchroniser stage is an ordinary flop and is cleared on reset, so the
  // edge detector never sees X or stale pin state after reset deassertion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_prev <= '0;
    end else begin
      // NOTE: non-blocking assignments let each stage take the previous stage's old
      // value, which is what makes this a shift chain rather than a single flop.
      r_sync[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev <= w_level;
    end
  end

  // Edges are ignored until both the chain and prev hold real pin samples.
  assign w_armed = (r_arm_cnt == CNT_W'(ARM_COUNT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_arm_cnt <= '0;
    end else if (!w_armed) begin
      r_arm_cnt <= r_arm_cnt + CNT_W'(1);
    end
  end

  assign w_rise = w_level & ~r_prev;
  assign w_fall = ~w_level & r_prev;

  // NOTE: a default is assigned first so no path leaves the output unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    w_edge_sel = w_rise | w_fall;
    if (EDGE_TYPE == 0)      w_edge_sel = w_rise;
    else if (EDGE_TYPE == 1) w_edge_sel = w_fall;
  end

  assign w_edge = w_armed ? w_edge_sel : '0;

  assign w_wr      = chipselect && !write_n;
  assign w_wr_mask = w_wr && (reg_addr_e'(address) == ADDR_IRQMASK);
  assign w_wr_cap  = w_wr && (reg_addr_e'(address) == ADDR_EDGECAP);
  assign w_clear   = w_wr_cap ? writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irq_mask <= '0;
    end else if (w_wr_mask) begin
      r_irq_mask <= writedata[WIDTH-1:0];
    end
  end

  // A new edge overrides a simultaneous clear of the same bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_edge_cap <= '0;
    end else begin
      r_edge_cap <= (r_edge_cap & ~w_clear) | w_edge;
    end
  end

  always_comb begin
    readdata = '0;
    case (reg_addr_e'(address))
      ADDR_DATA:    readdata[WIDTH-1:0] = w_level;
      ADDR_RSVD:    readdata            = '0;
      ADDR_IRQMASK: readdata[WIDTH-1:0] = r_irq_mask;
      ADDR_EDGECAP: readdata[WIDTH-1:0] = r_edge_cap;
      default:      readdata            = '0;
    endcase
  end

  assign irq = |(r_edge_cap & r_irq_mask);

endmodule

// File: tb/tb_first_nios2_system_button_pio.sv
// Directed bench for the button PIO: a falling-edge instance drives the vector table,
// an any-edge instance on the same bus covers arming and both-direction capture.
module tb_first_nios2_system_button_pio;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] readdata;
  logic        irq;
  logic [31:0] readdata2;
  logic        irq2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  first_nios2_system_button_pio #(.WIDTH(4), .EDGE_TYPE(1), .SYNC_STAGES(2)) u_dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  first_nios2_system_button_pio #(.WIDTH(4), .EDGE_TYPE(2), .SYNC_STAGES(2)) u_dut_any (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata2), .irq(irq2)
  );

  typedef struct {
    logic [3:0]  pins;
    logic        cs;
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_irq;
    logic        chk2;
    logic [31:0] exp_rd2;
    logic        exp_irq2;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Drive on the falling edge, then settle so combinational outputs can be sampled.
  task automatic drive(input logic [3:0] pins, input logic cs, input logic wr,
                       input logic [1:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    in_port    = pins;
    chipselect = cs;
    write_n    = ~wr;
    address    = addr;
    writedata  = wdata;
    #1;
  endtask

  function automatic vec_t mk(input logic [3:0] pins, input logic cs, input logic wr,
                              input logic [1:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rd, input logic exp_irq,
                              input logic chk2, input logic [31:0] exp_rd2,
                              input logic exp_irq2);
    vec_t v;
    v.pins = pins; v.cs = cs; v.wr = wr; v.addr = addr; v.wdata = wdata;
    v.exp_rd = exp_rd; v.exp_irq = exp_irq;
    v.chk2 = chk2; v.exp_rd2 = exp_rd2; v.exp_irq2 = exp_irq2;
    return v;
  endfunction

  initial begin
    reset      = 1'b1;
    in_port    = 4'hF;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;

    // Reset held with all pins high: every register reads zero.
    for (int a = 0; a < 4; a++) begin
      @(negedge clk);
      address = 2'(a);
      #1;
      check($sformatf("reset_rd_a%0d", a), readdata, 32'h0);
      check($sformatf("reset_rd2_a%0d", a), readdata2, 32'h0);
    end
    check("reset_irq", {31'b0, irq}, 32'h0);

    // Vector table: pin level, arming, falling capture, clear, mask, bus decode.
    vecs.push_back(mk(4'hF, 1, 0, 2'd0, 32'h0, 32'h0, 0, 0, 32'h0, 0));
    vecs.push_back(mk(4'hF, 1, 0, 2'd0, 32'h0, 32'hF, 0, 0, 32'h0, 0));
    vecs.push_back(mk(4'hF, 1, 0, 2'd3, 32'h0, 32'h0, 0, 1, 32'h0, 0));
    vecs.push_back(mk(4'hF, 1, 0, 2'd3, 32'h0, 32'h0, 0, 1, 32'h0, 0));
    vecs.push_back(mk(4'hF, 1, 1, 2'd2, 32'h1, 32'h0, 0, 0, 32'h0, 0));
    vecs.push_back(mk(4'hE, 1, 0, 2'd2, 32'h0, 32'h1, 0, 0, 32'h0, 0));
    vecs.push_back(mk(4'hE, 1, 0, 2'd0, 32'h0, 32'hF, 0, 0, 32'h0, 0));
    vecs.push_back(mk(4'hE, 1, 0, 2'd3, 32'h0, 32'h0, 0, 0, 32'h0, 0));
    vecs.push_back(mk(4'hE, 1, 0, 2'd3, 32'h0, 32'h1, 1, 0, 32'h0, 0));
    vecs.push_back(mk(4'hE, 1, 1, 2'd3, 32'h1, 32'h1, 1, 0, 32'h0, 0));
    vecs.push_back(mk(4'hE, 1, 0, 2'd3, 32'h0, 32'h0, 0, 0, 32'h0, 0));
    vecs.push_back(mk(4'hE, 1, 1, 2'd2, 32'h0, 32'h1, 0, 0, 32'h0, 0));
    vecs.push_back(mk(4'hA, 1, 0, 2'd2, 32'h0, 32'h0, 0, 0, 32'h0, 0));
    vecs.push_back(mk(4'hA, 1, 0, 2'd0, 32'h0, 32'hE, 0, 0, 32'h0, 0));
    vecs.push_back(mk(4'hA, 1, 0, 2'd0, 32'h0, 32'hA, 0, 0, 32'h0, 0));
    vecs.push_back(mk(4'hA, 1, 0, 2'd3, 32'h0, 32'h4, 0, 0, 32'h0, 0));
    vecs.push_back(mk(4'hA, 0, 1, 2'd2, 32'hF, 32'h0, 0, 0, 32'h0, 0));
    vecs.push_back(mk(4'hA, 1, 0, 2'd2, 32'h0, 32'h0, 0, 0, 32'h0, 0));
    vecs.push_back(mk(4'hA, 1, 1, 2'd2, 32'hFFFF_FFF4, 32'h0, 0, 0, 32'h0, 0));
    vecs.push_back(mk(4'hA, 1, 0, 2'd2, 32'h0, 32'h4, 1, 0, 32'h0, 0));
    vecs.push_back(mk(4'hA, 1, 0, 2'd1, 32'h0, 32'h0, 1, 0, 32'h0, 0));

    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].pins, vecs[i].cs, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      check($sformatf("vec%0d_rd", i), readdata, vecs[i].exp_rd);
      check($sformatf("vec%0d_irq", i), {31'b0, irq}, {31'b0, vecs[i].exp_irq});
      if (vecs[i].chk2) begin
        check($sformatf("vec%0d_rd2", i), readdata2, vecs[i].exp_rd2);
        check($sformatf("vec%0d_irq2", i), {31'b0, irq2}, {31'b0, vecs[i].exp_irq2});
      end
    end

    // Clear-write colliding with a fresh bit1 capture: the set wins.
    drive(4'hA, 1, 1, 2'd3, 32'hF);
    drive(4'hA, 1, 1, 2'd2, 32'h2);
    drive(4'h8, 1, 0, 2'd3, 32'h0);
    check("col_pre_rd", readdata, 32'h0);
    check("col_pre_irq", {31'b0, irq}, 32'h0);
    drive(4'h8, 1, 0, 2'd3, 32'h0);
    drive(4'hA, 1, 0, 2'd3, 32'h0);
    check("col_not_early", readdata, 32'h0);
    drive(4'h8, 1, 0, 2'd3, 32'h0);
    check("col_first_cap", readdata, 32'h2);
    check("col_first_irq", {31'b0, irq}, 32'h1);
    drive(4'h8, 1, 0, 2'd3, 32'h0);
    check("col_rise_ignored", readdata, 32'h2);
    drive(4'h8, 1, 1, 2'd3, 32'h2);
    drive(4'h8, 1, 0, 2'd3, 32'h0);
    check("col_set_wins_rd", readdata, 32'h2);
    check("col_set_wins_irq", {31'b0, irq}, 32'h1);
    drive(4'h8, 1, 1, 2'd3, 32'h2);
    drive(4'h8, 1, 0, 2'd3, 32'h0);
    check("col_clear_rd", readdata, 32'h0);
    check("col_clear_irq", {31'b0, irq}, 32'h0);

    // Any-edge instance: bit3 rises, is cleared, then falls five clocks later.
    for (int i = 0; i < 4; i++) drive(4'h0, 1, 0, 2'd3, 32'h0);
    drive(4'h0, 1, 1, 2'd3, 32'hF);
    drive(4'h0, 1, 0, 2'd3, 32'h0);
    check("any_cleared_rd2", readdata2, 32'h0);
    check("any_cleared_rd", readdata, 32'h0);
    drive(4'h8, 1, 0, 2'd3, 32'h0);
    drive(4'h8, 1, 0, 2'd1, 32'h0);
    check("any_rsvd_rd2", readdata2, 32'h0);
    drive(4'h8, 1, 0, 2'd3, 32'h0);
    check("any_rise_not_early", readdata2, 32'h0);
    drive(4'h8, 1, 0, 2'd3, 32'h0);
    check("any_rise_cap", readdata2, 32'h8);
    check("fall_only_ignores_rise", readdata, 32'h0);
    drive(4'h8, 1, 1, 2'd3, 32'h8);
    drive(4'h0, 1, 0, 2'd3, 32'h0);
    check("any_rise_cleared", readdata2, 32'h0);
    drive(4'h0, 1, 0, 2'd3, 32'h0);
    drive(4'h0, 1, 0, 2'd3, 32'h0);
    check("any_fall_not_early", readdata2, 32'h0);
    drive(4'h0, 1, 0, 2'd3, 32'h0);
    check("any_fall_cap", readdata2, 32'h8);
    check("any_fall_irq_masked", {31'b0, irq2}, 32'h0);
    check("fall_only_fall_cap", readdata, 32'h8);
    drive(4'h0, 1, 0, 2'd1, 32'h0);
    check("any_rsvd_rd2_set", readdata2, 32'h0);
    check("rsvd_rd_set", readdata, 32'h0);

    // Fill EDGECAP and IRQMASK, then reset asynchronously mid-cycle.
    drive(4'h0, 1, 1, 2'd2, 32'hF);
    drive(4'hF, 1, 0, 2'd3, 32'h0);
    check("fill_unmask_rd", readdata, 32'h8);
    check("fill_unmask_irq", {31'b0, irq}, 32'h1);
    for (int i = 0; i < 3; i++) drive(4'hF, 1, 0, 2'd3, 32'h0);
    for (int i = 0; i < 4; i++) drive(4'h0, 1, 0, 2'd3, 32'h0);
    check("fill_rd", readdata, 32'hF);
    check("fill_irq", {31'b0, irq}, 32'h1);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("rst_cap_rd", readdata, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    check("rst_cap_rd2", readdata2, 32'h0);
    check("rst_irq2", {31'b0, irq2}, 32'h0);
    address = 2'd2;
    #1;
    check("rst_mask_rd", readdata, 32'h0);
    address = 2'd0;
    #1;
    check("rst_data_rd", readdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
